xtea_stream_ctrl: RTL

- Upstream/downstream adapter for the dual-core XTEA block (2×64-bit lanes, shared key, shared valid/busy).
- Accepts a valid/ready stream of 64-bit blocks and pairs them into lane A/B.
- Issues each pair to the dual core and waits for its joint result valid.
- Re-serialises the results onto an in-order 64-bit valid/ready output stream, with correct handling of odd trailing blocks and a watchdog on a hung core.

---
 rtl/xtea_pkg.sv | 17 +
 rtl/xtea_watchdog.sv | 40 ++++
 rtl/xtea_stream_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/xtea_pkg.sv
// Shared types and widths for the XTEA stream controller.
package xtea_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 128;

  // Controller phases: fill both lanes, hand the pair to the core, wait, then drain in order.
  typedef enum logic [2:0] {
    FILL_A,
    FILL_B,
    ISSUE,
    WAIT,
    DRAIN_A,
    DRAIN_B
  } state_t;

endpackage

// File: rtl/xtea_watchdog.sv
// Wait-cycle timer with clear/enable, expiry compare and a sticky timeout flag.
module xtea_watchdog #(
  parameter int unsigned TIMEOUT = 1023,  // at least 1
  parameter int unsigned TW      = 10     // 2**TW must exceed TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic set,
  output logic expired,
  output logic flag
);

  logic [TW-1:0] timer;

  // Timer restarts on each issue and counts every cycle spent waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (en) begin
      timer <= timer + TW'(1);
    end
  end

  // Last permitted waiting cycle; the pair is abandoned at its end unless a result arrives.
  assign expired = (timer == TW'(TIMEOUT - 1));

  // Sticky flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (set) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/xtea_stream_ctrl.sv
// Pairs a 64-bit block stream into the two lanes of a dual XTEA core and re-serialises the
// results in order, with odd-tail handling and a watchdog on a hung core.
module xtea_stream_ctrl
  import xtea_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 10
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [BLOCK_W-1:0] s_data_i,
  input  logic               s_valid_i,
  input  logic               s_last_i,
  output logic               s_ready_o,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               decrypt_i,
  output logic [BLOCK_W-1:0] m_data_o,
  output logic               m_valid_o,
  output logic               m_last_o,
  input  logic               m_ready_i,
  output logic [BLOCK_W-1:0] core_data_a_o,
  output logic [BLOCK_W-1:0] core_data_b_o,
  output logic [KEY_W-1:0]   core_key_o,
  output logic               core_decrypt_o,
  output logic               core_valid_o,
  output logic               core_en_o,
  input  logic [BLOCK_W-1:0] core_result_a_i,
  input  logic [BLOCK_W-1:0] core_result_b_i,
  input  logic               core_valid_i,
  input  logic               core_busy_i,
  output logic               busy_o,
  output logic               timeout_o
);

  state_t             state;
  logic [BLOCK_W-1:0] data_a;
  logic [BLOCK_W-1:0] data_b;
  logic [KEY_W-1:0]   key;
  logic               dec;
  logic               odd;
  logic               last;
  logic [BLOCK_W-1:0] res_a;
  logic [BLOCK_W-1:0] res_b;

  logic issue;
  logic expired;
  logic wd_flag;

  assign issue = (state == ISSUE) && !core_busy_i;

  xtea_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst_i),
    .clr    (issue),
    .en     (state == WAIT),
    .set    ((state == WAIT) && expired && !core_valid_i),
    .expired(expired),
    .flag   (wd_flag)
  );

  // Pair sequencing plus lane, key and result capture.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state  <= FILL_A;
      data_a <= '0;
      data_b <= '0;
      key    <= '0;
      dec    <= 1'b0;
      odd    <= 1'b0;
      last   <= 1'b0;
      res_a  <= '0;
      res_b  <= '0;
    end else begin
      unique case (state)
        FILL_A: begin
          if (s_valid_i) begin
            data_a <= s_data_i;
            key    <= key_i;
            dec    <= decrypt_i;
            if (s_last_i) begin
              // Odd tail: lane B carries zeros and its result is never emitted.
              odd    <= 1'b1;
              data_b <= '0;
              last   <= 1'b1;
              state  <= ISSUE;
            end else begin
              state <= FILL_B;
            end
          end
        end
        FILL_B: begin
          if (s_valid_i) begin
            data_b <= s_data_i;
            odd    <= 1'b0;
            last   <= s_last_i;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!core_busy_i) state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle still wins.
          if (core_valid_i) begin
            res_a <= core_result_a_i;
            res_b <= core_result_b_i;
            state <= DRAIN_A;
          end else if (expired) begin
            state <= FILL_A;
          end
        end
        DRAIN_A: begin
          if (m_ready_i) state <= odd ? FILL_A : DRAIN_B;
        end
        DRAIN_B: begin
          if (m_ready_i) state <= FILL_A;
        end
        default: state <= FILL_A;
      endcase
    end
  end

  // Outputs decode from registered state and are forced low while reset is held.
  always_comb begin
    s_ready_o      = 1'b0;
    m_valid_o      = 1'b0;
    m_data_o       = '0;
    m_last_o       = 1'b0;
    core_data_a_o  = '0;
    core_data_b_o  = '0;
    core_key_o     = '0;
    core_decrypt_o = 1'b0;
    core_valid_o   = 1'b0;
    core_en_o      = 1'b0;
    busy_o         = 1'b0;
    timeout_o      = 1'b0;
    if (!rst_i) begin
      s_ready_o      = (state == FILL_A) || (state == FILL_B);
      m_valid_o      = (state == DRAIN_A) || (state == DRAIN_B);
      if (state == DRAIN_A) begin
        m_data_o = res_a;
        m_last_o = odd & last;
      end else if (state == DRAIN_B) begin
        m_data_o = res_b;
        m_last_o = last;
      end
      core_data_a_o  = data_a;
      core_data_b_o  = data_b;
      core_key_o     = key;
      core_decrypt_o = dec;
      core_valid_o   = issue;
      core_en_o      = 1'b1;
      busy_o         = !s_ready_o;
      timeout_o      = wd_flag;
    end
  end

endmodule
